// File: rtl/exp_lane_collector_pkg.sv
// Shared VFU definitions for the exp lane collector: FP16 width, default
// lane FIFO depth and the width helper used for pointers and counts.
package exp_lane_collector_pkg;

  localparam int unsigned FP16_W        = 16;
  localparam int unsigned DEFAULT_DEPTH = 4;

  function automatic int unsigned vfu_clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = value - 32'd1;
    r = 32'd0;
    while (v != 32'd0) begin
      r = r + 32'd1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/exp_lane_collector_lane_fifo.sv
// Single-lane FIFO; a push into a full lane is only taken when a pop frees
// the head slot in the same cycle, otherwise it is ignored here.
module lane_fifo
  import exp_lane_collector_pkg::*;
#(
  parameter  int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned PTR_W = vfu_clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [FP16_W-1:0] din,
  output logic [FP16_W-1:0] dout,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [FP16_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              full_s;
  logic              push_ok_s;

  assign full_s    = (count_r == CNT_W'(DEPTH));
  assign push_ok_s = push && (!full_s || pop);

  // pointer and occupancy state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_ok_s, pop})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // storage is intentionally not reset; only pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = full_s;
  assign empty = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/exp_lane_collector.sv
// Collects per-lane FP16 exp results into lane FIFOs and emits one aligned
// N-wide vector on a valid/ready stream once every lane has an entry.
module exp_lane_collector
  import exp_lane_collector_pkg::*;
#(
  parameter  int unsigned N     = 4,
  parameter  int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned CNT_W = vfu_clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          lane_tvalid,
  input  logic [N*FP16_W-1:0]   lane_data_flat,
  output logic [N-1:0]          lane_full,
  output logic                  overflow,
  output logic                  vec_tvalid,
  input  logic                  vec_tready,
  output logic [N*FP16_W-1:0]   vec_tdata_flat
);

  logic [CNT_W-1:0] count_s [N];
  logic [N-1:0]     empty_s;
  logic [N-1:0]     drop_s;
  logic             pop_s;
  logic             overflow_r;

  for (genvar i = 0; i < N; i++) begin : g_lane
    lane_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (lane_tvalid[i]),
      .pop   (pop_s),
      .din   (lane_data_flat[i*FP16_W +: FP16_W]),
      .dout  (vec_tdata_flat[i*FP16_W +: FP16_W]),
      .count (count_s[i]),
      .full  (lane_full[i]),
      .empty (empty_s[i])
    );
    // a strobe into a full lane is lost unless the shared pop frees a slot
    assign drop_s[i] = lane_tvalid[i] && (count_s[i] == CNT_W'(DEPTH)) && !pop_s;
  end

  assign vec_tvalid = ~(|empty_s);
  assign pop_s      = vec_tvalid && vec_tready;

  // sticky overflow flag, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_r <= 1'b0;
    end else if (|drop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign overflow = overflow_r;

endmodule

// File: tb/tb_exp_lane_collector.sv
// Self-checking bench for exp_lane_collector: constant vector tables, directed
// corner sequences and a randomized run against a queue-based lane model.
module tb_exp_lane_collector;

  localparam int N     = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  lane_tvalid;
  logic [63:0]   lane_data_flat;
  logic [N-1:0]  lane_full;
  logic          overflow;
  logic          vec_tvalid;
  logic          vec_tready;
  logic [63:0]   vec_tdata_flat;

  exp_lane_collector #(.N(N), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .lane_tvalid    (lane_tvalid),
    .lane_data_flat (lane_data_flat),
    .lane_full      (lane_full),
    .overflow       (overflow),
    .vec_tvalid     (vec_tvalid),
    .vec_tready     (vec_tready),
    .vec_tdata_flat (vec_tdata_flat)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] mq [N][$];
  logic        m_ovf;
  logic [63:0] out_q [$];

  typedef struct {
    logic [3:0]  tv;
    logic [63:0] d;
    logic        rdy;
    logic        ev;
    logic [63:0] ed;
  } row_t;

  row_t tbl [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rep(input logic [15:0] v);
    return {v, v, v, v};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) mq[i].delete();
    m_ovf = 1'b0;
  endtask

  // one clock: drive inputs, compare outputs with the model, advance both
  task automatic cyc(input logic [3:0] tv, input logic [63:0] d, input logic rdy);
    logic        ev;
    logic [63:0] ed;
    logic [3:0]  ef;
    lane_tvalid    = tv;
    lane_data_flat = d;
    vec_tready     = rdy;
    ev = 1'b1;
    ed = 64'h0;
    ef = 4'h0;
    for (int i = 0; i < N; i++) begin
      if (mq[i].size() == 0) ev = 1'b0;
      else ed[i*16 +: 16] = mq[i][0];
      if (mq[i].size() == DEPTH) ef[i] = 1'b1;
    end
    chk("vec_tvalid", {63'h0, vec_tvalid}, {63'h0, ev});
    chk("lane_full", {60'h0, lane_full}, {60'h0, ef});
    chk("overflow", {63'h0, overflow}, {63'h0, m_ovf});
    if (ev) chk("vec_tdata", vec_tdata_flat, ed);
    @(posedge clk);
    if (ev && rdy) begin
      out_q.push_back(ed);
      for (int i = 0; i < N; i++) void'(mq[i].pop_front());
    end
    for (int i = 0; i < N; i++) begin
      if (tv[i]) begin
        if (mq[i].size() < DEPTH) mq[i].push_back(d[i*16 +: 16]);
        else m_ovf = 1'b1;
      end
    end
    #1;
  endtask

  initial begin
    int s;
    int pc [N];
    int guard;
    logic [3:0]  tv;
    logic [63:0] d;

    tbl[0]  = '{4'hF, 64'hC034_4051_3EFA_BC00, 1'b1, 1'b0, 64'h0};
    tbl[1]  = '{4'h0, 64'h0, 1'b1, 1'b1, 64'hC034_4051_3EFA_BC00};
    tbl[2]  = '{4'h0, 64'h0, 1'b1, 1'b0, 64'h0};
    tbl[3]  = '{4'h1, 64'h0000_0000_0000_1111, 1'b1, 1'b0, 64'h0};
    tbl[4]  = '{4'h4, 64'h0000_3333_0000_0000, 1'b1, 1'b0, 64'h0};
    tbl[5]  = '{4'h0, 64'h0, 1'b1, 1'b0, 64'h0};
    tbl[6]  = '{4'h2, 64'h0000_0000_2222_0000, 1'b1, 1'b0, 64'h0};
    tbl[7]  = '{4'h0, 64'h0, 1'b1, 1'b0, 64'h0};
    tbl[8]  = '{4'h8, 64'h4444_0000_0000_0000, 1'b1, 1'b0, 64'h0};
    tbl[9]  = '{4'h0, 64'h0, 1'b1, 1'b1, 64'h4444_3333_2222_1111};
    tbl[10] = '{4'h0, 64'h0, 1'b1, 1'b0, 64'h0};

    rst = 1'b0;
    lane_tvalid = 4'h0;
    lane_data_flat = 64'h0;
    vec_tready = 1'b0;
    model_clear();
    #12;
    chk("reset_valid", {63'h0, vec_tvalid}, 64'h0);
    chk("reset_full", {60'h0, lane_full}, 64'h0);
    chk("reset_ovf", {63'h0, overflow}, 64'h0);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // aligned and skewed lanes from the constant table
    for (int r = 0; r < 11; r++) begin
      chk($sformatf("tbl%0d_valid", r), {63'h0, vec_tvalid}, {63'h0, tbl[r].ev});
      if (tbl[r].ev) chk($sformatf("tbl%0d_data", r), vec_tdata_flat, tbl[r].ed);
      cyc(tbl[r].tv, tbl[r].d, tbl[r].rdy);
    end

    // backpressure
    for (int k = 1; k <= 4; k++) cyc(4'hF, rep(16'(k)), 1'b0);
    chk("bp_full", {60'h0, lane_full}, 64'hF);
    chk("bp_head", vec_tdata_flat, rep(16'h0001));
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("bp_pop%0d", k), vec_tdata_flat, rep(16'(k)));
      cyc(4'h0, 64'h0, 1'b1);
    end
    chk("bp_empty", {63'h0, vec_tvalid}, 64'h0);

    // overflow with tready low
    for (int k = 1; k <= 4; k++) cyc(4'hF, rep(16'h0010 + 16'(k)), 1'b0);
    cyc(4'h2, 64'h0000_0000_DEAD_0000, 1'b0);
    chk("ovf_set", {63'h0, overflow}, 64'h1);
    chk("ovf_head", vec_tdata_flat, rep(16'h0011));
    cyc(4'h0, 64'h0, 1'b1);
    cyc(4'h0, 64'h0, 1'b1);

    // asynchronous reset pulse mid-cycle with two vectors buffered
    #2 rst = 1'b0;
    #3;
    chk("rst_valid", {63'h0, vec_tvalid}, 64'h0);
    chk("rst_full", {60'h0, lane_full}, 64'h0);
    chk("rst_ovf", {63'h0, overflow}, 64'h0);
    rst = 1'b1;
    model_clear();
    cyc(4'hF, rep(16'h0077), 1'b1);
    chk("rst_first", vec_tdata_flat, rep(16'h0077));
    cyc(4'h0, 64'h0, 1'b1);
    chk("rst_drained", {63'h0, vec_tvalid}, 64'h0);

    // full lanes with simultaneous pop accept the push
    for (int k = 1; k <= 4; k++) cyc(4'hF, rep(16'h0020 + 16'(k)), 1'b0);
    cyc(4'hF, 64'hBEEF_BEEF_DEAD_BEEF, 1'b1);
    chk("popfull_ovf", {63'h0, overflow}, 64'h0);
    s = out_q.size();
    for (int k = 0; k < 4; k++) cyc(4'h0, 64'h0, 1'b1);
    chk("dead_fourth", {48'h0, out_q[s+3][31:16]}, 64'hDEAD);
    chk("dead_ovf", {63'h0, overflow}, 64'h0);

    // wrap-around with random skew and random tready
    s = out_q.size();
    for (int i = 0; i < N; i++) pc[i] = 0;
    guard = 0;
    while (out_q.size() - s < 3 * DEPTH && guard < 400) begin
      tv = 4'h0;
      d  = 64'h0;
      for (int i = 0; i < N; i++) begin
        if (pc[i] < 3 * DEPTH && mq[i].size() < DEPTH && $urandom_range(0, 1) == 1) begin
          tv[i] = 1'b1;
          d[i*16 +: 16] = 16'(i * 16'h1000 + 16'h0A00 + pc[i]);
          pc[i]++;
        end
      end
      cyc(tv, d, 1'($urandom_range(0, 1)));
      guard++;
    end
    chk("wrap_count", 64'(out_q.size() - s), 64'(3 * DEPTH));
    for (int k = 0; k < 3 * DEPTH; k++) begin
      if (s + k < out_q.size()) begin
        for (int i = 0; i < N; i++) d[i*16 +: 16] = 16'(i * 16'h1000 + 16'h0A00 + k);
        chk($sformatf("wrap_vec%0d", k), out_q[s+k], d);
      end
    end
    chk("wrap_ovf", {63'h0, overflow}, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exp_lane_collector.md
# exp_lane_collector

Receive-side companion to `exp_module` in the softmax DFX VFU. It captures the per-lane FP16 results that `exp_module` emits on `out_tvalid[i]`/`exp_out_flat`. Each lane is buffered in its own small FIFO, because lanes may complete in different cycles and `exp_module` offers no output backpressure. When every lane holds a result, the block presents one lane-aligned N-wide vector on a valid/ready stream to the downstream accumulate/normalise stage.

## Interface
- `N`, default 4: number of lanes; must match `exp_module`.
- `DEPTH`, default 4: entries per lane FIFO; power of two, ≥2.
- `clk`  input  1  rising-edge clock, sole clock domain.
- `rst`  input  1  asynchronous, active-low reset (0 = reset asserted).
- `lane_tvalid`  input  N  per-lane result strobe, wired to `exp_module.out_tvalid`.
- `lane_data_flat`  input  N*16  FP16 results; lane i at bits [i*16 +: 16].
- `lane_full`  output  N  lane i FIFO holds DEPTH entries; upstream issue logic must not launch a new lane-i operation while this is set.
- `overflow`  output  1  sticky; set when a push arrives at a full lane with no pop in the same cycle.
- `vec_tvalid`  output  1  an aligned vector is available.
- `vec_tready`  input  1  downstream accepts the vector.
- `vec_tdata_flat`  output  N*16  head entry of every lane FIFO; lane i at bits [i*16 +: 16].

## Operation
- One FIFO per lane, with `wr_ptr`, `rd_ptr` and `count` (width clog2(DEPTH)+1). Pointers wrap modulo DEPTH.
- Push, lane i: `lane_tvalid[i]`=1 and (count<DEPTH, or a pop occurs this cycle). The data is written at `wr_ptr`, and `wr_ptr` increments.
- Dropped push: `lane_tvalid[i]`=1, count==DEPTH and no pop this cycle. The data is discarded, FIFO state is unchanged, and `overflow` is set to 1. Only reset clears `overflow`.
- `vec_tvalid` = AND over lanes of (count≠0). It is combinational from registered counts.
- `vec_tdata_flat` = head entry (`mem[rd_ptr]`) of each lane. Values pass through bit-exact, with no FP16 interpretation.
- Pop: `vec_tvalid && vec_tready`. Every lane's `rd_ptr` increments and every lane's count decrements together.
- Push and pop on the same lane in the same cycle: count is unchanged and both pointers advance. This holds when the lane is full (the push is accepted, no overflow) and when count==1.
- A pop can never occur on an empty lane, because `vec_tvalid` requires every lane to be non-empty.
- Lanes whose data arrives early wait in their FIFOs. Order is preserved per lane.
- Vector k is always composed of the k-th accepted push of each lane.
- `lane_full[i]` = (count_i == DEPTH), registered-count based.

## Timing
- Reset (`rst`=0, asynchronous) sets all pointers and counts to 0 and `overflow`=0. As a result `vec_tvalid`=0 and `lane_full`=0. FIFO storage is not reset.
- `vec_tdata_flat` is don't-care while `vec_tvalid`=0.
- Reset asserted mid-operation flushes all buffered entries immediately. The first push is accepted on the first rising edge after `rst` rises.
- Latency: the last lane pushed at edge k gives `vec_tvalid`=1 in the cycle after edge k, i.e. one cycle of latency.
- Throughput: one vector per cycle while all lanes are non-empty and `vec_tready`=1.
- Stream rules:
  - Once `vec_tvalid` is high, it and `vec_tdata_flat` stay stable until the handshake; pushes do not alter the heads.
  - `vec_tvalid` does not depend combinationally on `vec_tready`.
- `lane_full` reflects the count after the previous edge and updates one cycle after the push or pop that changes it.

## Structure
- Shared VFU package holds:
  - `FP16_W` = 16;
  - the clog2 helper for pointer and count widths;
  - the default `DEPTH`.
- Sub-module `lane_fifo`: a single-lane FIFO with `push`, `pop`, `din`, `dout`, `count`, `full`, `empty`. It is instantiated N times through a generate loop.
- The top level holds the `vec_tvalid` AND-reduction, pop fan-out and the `overflow` register.

## Test plan
- **Aligned lanes.** Reset, then push 16'hBC00, 16'h3EFA, 16'h4051, 16'hC034 on lanes 0–3 in one cycle with `vec_tready`=1. Required: `vec_tvalid`=1 the next cycle with `vec_tdata_flat`=64'hC034_4051_3EFA_BC00, popped in that cycle, then `vec_tvalid`=0.
- **Skewed lanes.** Push lane 0 at cycle 0, lane 2 at cycle 1, lane 1 at cycle 3 and lane 3 at cycle 5. Required: `vec_tvalid` stays 0 through cycle 5, rises at cycle 6, and the data matches the pushed values.
- **Backpressure.** Hold `vec_tready`=0 and push 4 vectors, values 16'h0001–16'h0004 per lane. Required: `lane_full`=4'hF and `vec_tdata_flat` stays at the 16'h0001 vector. Then release `vec_tready`: four consecutive pops of 0001, 0002, 0003, 0004, then `vec_tvalid`=0.
- **Overflow.** With lane 1 full and `vec_tready`=0, push 16'hDEAD on lane 1. Required: `overflow`=1 and the lane 1 contents are unchanged. Repeat with `vec_tready`=1: the push is accepted, `overflow` does not newly set, and DEAD emerges fourth.
- **Wrap-around.** Run 3·DEPTH vectors of incrementing data with random `vec_tready`. Required: output order and values match the input exactly and `overflow`=0.
- **Reset mid-operation.** With 2 vectors buffered, pulse `rst`=0 for 3 ns off-edge. Required: `vec_tvalid`, `lane_full` and `overflow` drop to 0 immediately, and the next pushed vector is the first one output.
